// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core: sequences ALU, register file and unified memory,
// stalls on MemReady and halts on illegal opcodes or bus timeouts.
module multicycle_ctrl #(
  parameter int unsigned WAIT_MAX        = 15,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       Lt,
  input  logic       Ltu,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       RegWrite,
  output logic       Halted,
  output logic [1:0] ErrCode,
  output logic [3:0] DbgState
);

  // Encoding is visible on DbgState, so it is fixed explicitly.
  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10,
    StHalt     = 4'd11
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluAnd  = 4'b0010;
  localparam logic [3:0] AluOr   = 4'b0011;
  localparam logic [3:0] AluXor  = 4'b0100;
  localparam logic [3:0] AluSlt  = 4'b0101;
  localparam logic [3:0] AluSrl  = 4'b0110;
  localparam logic [3:0] AluSra  = 4'b0111;
  localparam logic [3:0] AluSll  = 4'b1000;
  localparam logic [3:0] AluSltu = 4'b1001;

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrIllegal = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [1:0] err_q, err_d;

  logic       waiting, timeout;
  logic       taken, br_legal;
  logic [3:0] alu_dec;
  logic       pc_write, mem_write, ir_write, reg_write;

  assign waiting = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
  // The cycle that would be the WAIT_MAX-th stalled cycle is the timeout cycle.
  assign timeout = waiting && !MemReady && (WAIT_MAX != 0) &&
                   ((32'(wait_cnt_q) + 32'd1) >= WAIT_MAX);

  always_comb begin
    unique case (funct3)
      3'b000: alu_dec = (funct7b5 && op[5]) ? AluSub : AluAdd;
      3'b001: alu_dec = AluSll;
      3'b010: alu_dec = AluSlt;
      3'b011: alu_dec = AluSltu;
      3'b100: alu_dec = AluXor;
      3'b101: alu_dec = funct7b5 ? AluSra : AluSrl;
      3'b110: alu_dec = AluOr;
      3'b111: alu_dec = AluAnd;
    endcase
  end

  always_comb begin
    taken    = 1'b0;
    br_legal = 1'b1;
    unique case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      3'b100:  taken = Lt;
      3'b101:  taken = !Lt;
      3'b110:  taken = Ltu;
      3'b111:  taken = !Ltu;
      default: br_legal = 1'b0;
    endcase
  end

  always_comb begin
    unique case (op)
      OpStore:  ImmSrc = 2'b01;
      OpBranch: ImmSrc = 2'b10;
      OpJal:    ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    pc_write   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = AluAdd;
    Halted     = 1'b0;

    unique case (state_q)
      StFetch: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_write  = MemReady;
        pc_write  = MemReady;
        if (MemReady) begin
          state_d = StDecode;
        end else if (timeout) begin
          state_d = StHalt;
          err_d   = ErrTimeout;
        end
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        unique case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          default: begin
            if (HALT_ON_ILLEGAL) begin
              state_d = StHalt;
              err_d   = ErrIllegal;
            end else begin
              state_d = StFetch;
            end
          end
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = op[5] ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        AdrSrc = 1'b1;
        if (MemReady) begin
          state_d = StMemWb;
        end else if (timeout) begin
          state_d = StHalt;
          err_d   = ErrTimeout;
        end
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StMemWrite: begin
        AdrSrc    = 1'b1;
        mem_write = !timeout;
        if (MemReady) begin
          state_d = StFetch;
        end else if (timeout) begin
          state_d = StHalt;
          err_d   = ErrTimeout;
        end
      end
      StExecR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec;
        state_d    = StAluWb;
      end
      StExecI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec;
        state_d    = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        ALUSrcA    = 2'b10;
        ALUControl = AluSub;
        if (br_legal) begin
          pc_write = taken;
          state_d  = StFetch;
        end else if (HALT_ON_ILLEGAL) begin
          state_d = StHalt;
          err_d   = ErrIllegal;
        end else begin
          state_d = StFetch;
        end
      end
      StJal: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pc_write = 1'b1;
        state_d  = StAluWb;
      end
      StHalt: begin
        Halted = 1'b1;
      end
      default: begin
        state_d = StHalt;
      end
    endcase

    if (state_d != state_q) begin
      wait_cnt_d = 8'd0;
    end else if (waiting && !MemReady) begin
      wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StFetch;
      wait_cnt_q <= 8'd0;
      err_q      <= ErrNone;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  // Enables are masked combinationally so nothing fires while reset is held low.
  assign PCWrite  = pc_write && reset;
  assign MemWrite = mem_write && reset;
  assign IRWrite  = ir_write && reset;
  assign RegWrite = reg_write && reset;
  assign ErrCode  = err_q;
  assign DbgState = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: builds per-instruction cycle sequences from the ISA-level rules,
// replays them as stimulus and checks every cycle, then pins a few directed cases with literals.
module tb_multicycle_ctrl;

  localparam int unsigned WaitMax = 15;

  localparam logic [3:0] SFetch = 4'd0, SDecode = 4'd1, SMemAdr = 4'd2, SMemRead = 4'd3;
  localparam logic [3:0] SMemWb = 4'd4, SMemWrite = 4'd5, SExecR = 4'd6, SExecI = 4'd7;
  localparam logic [3:0] SAluWb = 4'd8, SBranch = 4'd9, SJal = 4'd10, SHalt = 4'd11;

  localparam int KR = 0, KI = 1, KLd = 2, KSt = 3, KBr = 4, KJal = 5, KIll = 6;

  // add, sll, slt, sltu, xor, srl, or, and indexed by funct3
  localparam logic [3:0] AluTbl [8] = '{4'h0, 4'h8, 4'h5, 4'h9, 4'h4, 4'h6, 4'h3, 4'h2};

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] imm;
    logic [3:0] alu;
    logic       rw;
    logic       halted;
    logic [1:0] err;
  } obs_t;

  typedef struct packed {
    logic       rst;
    logic       mr;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    logic       lt;
    logic       ltu;
    obs_t       o;
  } step_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, Lt, Ltu, MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Halted;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ErrCode;
  logic [3:0] ALUControl, DbgState;

  always #5 clk = ~clk;

  multicycle_ctrl #(
    .WAIT_MAX       (WaitMax),
    .HALT_ON_ILLEGAL(1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .Zero      (Zero),
    .Lt        (Lt),
    .Ltu       (Ltu),
    .MemReady  (MemReady),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ImmSrc    (ImmSrc),
    .ALUControl(ALUControl),
    .RegWrite  (RegWrite),
    .Halted    (Halted),
    .ErrCode   (ErrCode),
    .DbgState  (DbgState)
  );

  step_t      plan[$];
  obs_t       hist[$];
  obs_t       exp_o;
  logic       exp_valid = 1'b0;
  int         checks = 0;
  int         failures = 0;

  logic [6:0]  c_op;
  logic [2:0]  c_f3;
  logic        c_f7;
  logic [31:0] c_a, c_b;
  logic [1:0]  m_err;
  bit          m_halted;

  function automatic logic [1:0] imm_ref(input logic [6:0] o);
    case (o)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] alu_ref();
    if (c_f3 == 3'd0 && c_f7 && c_op[5]) return 4'h1;
    if (c_f3 == 3'd5 && c_f7) return 4'h7;
    return AluTbl[c_f3];
  endfunction

  // Branch outcome from the operands themselves, not from the flag wires.
  function automatic logic taken_ref();
    case (c_f3)
      3'd0:    return c_a == c_b;
      3'd1:    return c_a != c_b;
      3'd4:    return $signed(c_a) < $signed(c_b);
      3'd5:    return $signed(c_a) >= $signed(c_b);
      3'd6:    return c_a < c_b;
      3'd7:    return c_a >= c_b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic obs_t outs(input logic [3:0] st, input logic mr);
    obs_t o;
    o     = '0;
    o.st  = st;
    o.err = m_err;
    o.imm = imm_ref(c_op);
    case (st)
      SFetch:    begin o.sb = 2'b10; o.rs = 2'b10; o.irw = mr; o.pcw = mr; end
      SDecode:   begin o.sa = 2'b01; o.sb = 2'b01; end
      SMemAdr:   begin o.sa = 2'b10; o.sb = 2'b01; end
      SMemRead:  o.adr = 1'b1;
      SMemWb:    begin o.rs = 2'b01; o.rw = 1'b1; end
      SMemWrite: begin o.adr = 1'b1; o.mw = 1'b1; end
      SExecR:    begin o.sa = 2'b10; o.alu = alu_ref(); end
      SExecI:    begin o.sa = 2'b10; o.sb = 2'b01; o.alu = alu_ref(); end
      SAluWb:    o.rw = 1'b1;
      SBranch:   begin o.sa = 2'b10; o.alu = 4'h1; o.pcw = taken_ref(); end
      SJal:      begin o.sa = 2'b01; o.sb = 2'b10; o.pcw = 1'b1; end
      SHalt:     o.halted = 1'b1;
      default:   ;
    endcase
    return o;
  endfunction

  task automatic set_ctx(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b);
    c_op = o; c_f3 = f3; c_f7 = f7; c_a = a; c_b = b;
  endtask

  task automatic push_raw(input logic rst, input logic mr, input obs_t o);
    step_t s;
    s.rst = rst; s.mr = mr; s.op = c_op; s.f3 = c_f3; s.f7 = c_f7;
    s.z   = (c_a == c_b);
    s.lt  = ($signed(c_a) < $signed(c_b));
    s.ltu = (c_a < c_b);
    s.o   = o;
    plan.push_back(s);
  endtask

  task automatic push_mr(input logic [3:0] st, input logic mr);
    push_raw(1'b0, mr, outs(st, mr));
  endtask

  task automatic push(input logic [3:0] st);
    push_mr(st, 1'($urandom));
  endtask

  task automatic push_halt(input int n);
    repeat (n) push(SHalt);
  endtask

  task automatic push_reset(input int n);
    logic mr;
    obs_t o;
    m_err    = 2'b00;
    m_halted = 1'b0;
    repeat (n) begin
      mr    = 1'($urandom);
      o     = outs(SFetch, mr);
      o.irw = 1'b0;
      o.pcw = 1'b0;
      push_raw(1'b1, mr, o);
    end
  endtask

  // n stalled cycles then one ready cycle, unless the stall limit hits first.
  task automatic wait_phase(input logic [3:0] st, input int n, output bit to);
    obs_t o;
    to = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (WaitMax != 0 && k + 1 >= int'(WaitMax)) begin
        o    = outs(st, 1'b0);
        o.mw = 1'b0;
        push_raw(1'b0, 1'b0, o);
        m_err    = 2'b10;
        m_halted = 1'b1;
        to       = 1'b1;
        return;
      end
      push_mr(st, 1'b0);
    end
    push_mr(st, 1'b1);
  endtask

  task automatic gen(input int kind, input int fw, input int mw);
    bit to;
    wait_phase(SFetch, fw, to);
    if (to) return;
    push(SDecode);
    case (kind)
      KR:   begin push(SExecR); push(SAluWb); end
      KI:   begin push(SExecI); push(SAluWb); end
      KLd:  begin push(SMemAdr); wait_phase(SMemRead, mw, to); if (!to) push(SMemWb); end
      KSt:  begin push(SMemAdr); wait_phase(SMemWrite, mw, to); end
      KBr:  begin
        push(SBranch);
        if (c_f3[2:1] == 2'b01) begin m_err = 2'b01; m_halted = 1'b1; end
      end
      KJal: begin push(SJal); push(SAluWb); end
      default: begin m_err = 2'b01; m_halted = 1'b1; end
    endcase
  endtask

  function automatic int rand_wait();
    int r;
    r = int'($urandom_range(9, 0));
    if (r < 8) return int'($urandom_range(3, 0));
    if (r == 8) return int'($urandom_range(13, 4));
    return int'($urandom_range(16, 14));
  endfunction

  task automatic rand_ctx(output int kind);
    int r;
    logic [6:0] o;
    logic [2:0] f3;
    logic [31:0] a, b;
    r  = int'($urandom_range(19, 0));
    f3 = 3'($urandom);
    a  = $urandom;
    b  = ($urandom_range(3, 0) == 0) ? a : $urandom;
    if (r < 4) begin kind = KR; o = 7'b0110011; end
    else if (r < 7) begin kind = KI; o = 7'b0010011; end
    else if (r < 10) begin kind = KLd; o = 7'b0000011; end
    else if (r < 13) begin kind = KSt; o = 7'b0100011; end
    else if (r < 17) begin
      kind = KBr; o = 7'b1100011;
      if ($urandom_range(9, 0) != 0 && f3[2:1] == 2'b01) f3[2] = 1'b1;
    end
    else if (r < 19) begin kind = KJal; o = 7'b1101111; end
    else begin
      kind = KIll;
      o    = 7'($urandom);
      while (o == 7'b0110011 || o == 7'b0010011 || o == 7'b0000011 || o == 7'b0100011 ||
             o == 7'b1100011 || o == 7'b1101111) o = 7'($urandom);
    end
    set_ctx(o, f3, 1'($urandom), a, b);
  endtask

  task automatic play();
    step_t s;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      @(negedge clk);
      reset    = ~s.rst;
      MemReady = s.mr;
      op       = s.op;
      funct3   = s.f3;
      funct7b5 = s.f7;
      Zero     = s.z;
      Lt       = s.lt;
      Ltu      = s.ltu;
      exp_o    = s.o;
      exp_valid = 1'b1;
    end
    @(negedge clk);
    exp_valid = 1'b0;
  endtask

  task automatic pin(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Single compare process: every replayed cycle is checked mid-cycle.
  initial begin
    obs_t act;
    forever begin
      @(negedge clk);
      #3;
      if (exp_valid) begin
        act = {DbgState, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
               ALUControl, RegWrite, Halted, ErrCode};
        hist.push_back(act);
        checks++;
        if (act !== exp_o) begin
          failures++;
          $display("FAIL cycle step=%0d got=%h want=%h", hist.size() - 1, act, exp_o);
        end
      end
    end
  end

  initial begin
    int i_r, i_l, i_s, i_b1, i_b2, i_h, i_hr, i_t, total, cnt, cnt2;
    reset = 1'b0; MemReady = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0;
    Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0;
    m_err = 2'b00; m_halted = 1'b0;
    set_ctx(7'b0110011, 3'b000, 1'b1, 32'd7, 32'd2);
    push_reset(3);

    i_r = plan.size();
    gen(KR, 0, 0);
    set_ctx(7'b0000011, 3'b010, 1'b0, 32'd0, 32'd4);
    i_l = plan.size();
    gen(KLd, 0, 3);
    set_ctx(7'b0100011, 3'b010, 1'b0, 32'd0, 32'd4);
    i_s = plan.size();
    gen(KSt, 0, 2);
    set_ctx(7'b1100011, 3'b101, 1'b0, 32'd5, 32'd3);
    i_b1 = plan.size();
    gen(KBr, 0, 0);
    set_ctx(7'b1100011, 3'b101, 1'b0, 32'hFFFF_FFFF, 32'd3);
    i_b2 = plan.size();
    gen(KBr, 0, 0);
    set_ctx(7'b1111111, 3'b000, 1'b0, 32'd0, 32'd0);
    i_h = plan.size();
    gen(KIll, 0, 0);
    push_halt(20);
    i_hr = plan.size();
    push_reset(2);
    set_ctx(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd2);
    i_t = plan.size();
    gen(KR, 15, 0);
    push_halt(3);
    push_reset(2);

    for (int n = 0; n < 250; n++) begin
      int kind, start, cut;
      rand_ctx(kind);
      start = plan.size();
      gen(kind, rand_wait(), rand_wait());
      if ($urandom_range(24, 0) == 0 && plan.size() > start + 1) begin
        cut = int'($urandom_range(plan.size() - 1, start + 1));
        while (plan.size() > cut) void'(plan.pop_back());
        push_reset(int'($urandom_range(2, 1)));
      end else if (m_halted) begin
        push_halt(int'($urandom_range(4, 1)));
        push_reset(int'($urandom_range(2, 1)));
      end
    end

    total = plan.size();
    play();
    #5;

    pin("steps_seen", hist.size(), total);
    if (hist.size() == total) begin
      pin("r_execr_state", int'(hist[i_r + 2].st), 6);
      pin("r_execr_alu", int'(hist[i_r + 2].alu), 1);
      pin("r_back_to_fetch", int'(hist[i_r + 4].st), 0);
      cnt = 0;
      for (int k = i_r; k < i_r + 4; k++) cnt += int'(hist[k].rw);
      pin("r_regwrite_cycles", cnt, 1);
      pin("r_aluwb_regwrite", int'(hist[i_r + 3].rw), 1);

      cnt = 0;
      for (int k = i_l; k < i_l + 8; k++) cnt += int'(hist[k].st == SMemRead);
      pin("lw_memread_cycles", cnt, 4);
      pin("lw_memwb_resultsrc", int'(hist[i_l + 7].rs), 1);
      pin("lw_memwb_regwrite", int'(hist[i_l + 7].rw), 1);

      cnt = 0; cnt2 = 0;
      for (int k = i_s; k < i_s + 7; k++) begin
        cnt  += int'(hist[k].mw);
        cnt2 += int'(hist[k].rw);
      end
      pin("sw_memwrite_cycles", cnt, 3);
      pin("sw_regwrite_cycles", cnt2, 0);
      pin("sw_adrsrc_last", int'(hist[i_s + 5].adr), 1);

      pin("bge_not_lt_taken", int'(hist[i_b1 + 2].pcw), 1);
      pin("bge_lt_not_taken", int'(hist[i_b2 + 2].pcw), 0);
      pin("bge_returns_fetch", int'(hist[i_b2 + 3].st), 0);

      cnt = 0;
      for (int k = i_h + 2; k < i_h + 22; k++) cnt += int'(hist[k].halted);
      pin("illegal_halt_cycles", cnt, 20);
      pin("illegal_errcode", int'(hist[i_h + 21].err), 1);
      pin("reset_clears_err", int'(hist[i_hr].err), 0);
      pin("reset_state_fetch", int'(hist[i_hr].st), 0);

      cnt = 0;
      for (int k = i_t; k < i_t + 18; k++) cnt += int'(hist[k].irw);
      pin("timeout_no_irwrite", cnt, 0);
      pin("timeout_last_wait_fetch", int'(hist[i_t + 14].st), 0);
      pin("timeout_halted", int'(hist[i_t + 15].halted), 1);
      pin("timeout_errcode", int'(hist[i_t + 15].err), 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
